// File: rtl/factorial_scheduler.sv
// Round-robin front end for one shared iterative factorial engine.
// Jobs from NREQ requesters are served one at a time; one multiply per clock.
module factorial_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int NW    = 5,
  parameter int IDW   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*NW-1:0]   n_in,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 done,
  output logic [IDW-1:0]       done_id,
  output logic [WIDTH-1:0]     result,
  output logic                 overflow
);

  // Handshake: req[k] is a level held by the client until grant[k] pulses for
  // one cycle; operand n_in[k] is captured on that same edge and may change after.
  localparam int IW = NW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [IDW-1:0]     ptr_q;
  logic [NREQ-1:0]    grant_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;
  logic [IDW-1:0]     done_id_q;
  logic               ovf_out_q;
  logic [NW-1:0]      n_q;
  logic [IDW-1:0]     id_q;
  logic [WIDTH-1:0]   acc_q;
  logic [IW-1:0]      idx_q;
  logic               ovf_q;

  logic               any_req;
  logic [IDW-1:0]     sel;
  logic [IDW-1:0]     cand;
  logic [IDW-1:0]     ptr_d;
  logic [NREQ-1:0]    sel_onehot;
  logic [NW-1:0]      n_sel;
  logic [2*WIDTH-1:0] prod;

  // First requesting client at or after ptr_q, wrapping at NREQ.
  always_comb begin
    any_req = 1'b0;
    sel     = '0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDW'((32'(ptr_q) + 32'(i)) % NREQ);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        sel     = cand;
      end
    end
  end

  always_comb begin
    n_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (sel == IDW'(k)) n_sel = n_in[k*NW +: NW];
    end
  end

  assign sel_onehot = NREQ'(1) << sel;
  assign ptr_d      = (sel == IDW'(NREQ-1)) ? '0 : sel + 1'b1;
  assign prod       = (2*WIDTH)'(acc_q) * (2*WIDTH)'(idx_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
      done_id_q <= '0;
      ovf_out_q <= 1'b0;
      n_q       <= '0;
      id_q      <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      grant_q <= '0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q <= sel_onehot;
            n_q     <= n_sel;
            id_q    <= sel;
            acc_q   <= WIDTH'(1);
            idx_q   <= IW'(1);
            ovf_q   <= 1'b0;
            ptr_q   <= ptr_d;
            state_q <= MUL;
          end
        end
        MUL: begin
          // idx is one bit wider than n so the exit test works at n = 2^NW-1.
          if (idx_q > {1'b0, n_q}) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            result_q  <= acc_q;
            done_id_q <= id_q;
            ovf_out_q <= ovf_q;
          end else begin
            acc_q <= prod[WIDTH-1:0];
            ovf_q <= ovf_q | (prod[2*WIDTH-1:WIDTH] != '0);
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant    = grant_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign done_id  = done_id_q;
  assign result   = result_q;
  assign overflow = ovf_out_q;

endmodule

// File: tb/tb_factorial_scheduler.sv
// Bench for factorial_scheduler: scoreboard of expected jobs pushed at grant,
// popped and compared at done.
module tb_factorial_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int NW    = 5;
  localparam int IDW   = 2;
  localparam int EW    = IDW + 1 + WIDTH + NW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*NW-1:0]   n_in;
  logic [NREQ-1:0]      grant;
  logic                 busy;
  logic                 done;
  logic [IDW-1:0]       done_id;
  logic [WIDTH-1:0]     result;
  logic                 overflow;

  logic [NW-1:0]        n_arr [NREQ];
  int                   n_snap [NREQ];

  logic [EW-1:0]        exp_q[$];
  int                   gcyc_q[$];
  int                   grant_exp_q[$];

  int                   checks = 0;
  int                   errors = 0;
  int                   cyc = 0;
  logic                 busy_prev;
  logic [WIDTH-1:0]     last_res;
  logic                 last_ovf;
  logic [IDW-1:0]       last_id;
  logic                 resub_valid;
  int                   resub_id;
  int                   resub_n;

  factorial_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .NW(NW), .IDW(IDW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .n_in     (n_in),
    .grant    (grant),
    .busy     (busy),
    .done     (done),
    .done_id  (done_id),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always_comb begin
    n_in = '0;
    for (int k = 0; k < NREQ; k++) n_in[k*NW +: NW] = n_arr[k];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: acc = acc*i for i = 1..n, truncated, sticky overflow.
  function automatic logic [WIDTH:0] fact_model(input int n);
    logic [63:0]      p;
    logic [WIDTH-1:0] acc;
    logic             ovf;
    acc = 1;
    ovf = 1'b0;
    for (int i = 1; i <= n; i++) begin
      p   = {32'b0, acc} * 64'(i);
      ovf = ovf | (p[63:32] != 0);
      acc = p[31:0];
    end
    return {ovf, acc};
  endfunction

  task automatic tick();
    logic [WIDTH:0] m;
    logic [EW-1:0]  ent;
    int             g;
    int             gc;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      check_eq("rst_done", done, 0);
    end else begin
      if (grant != '0) begin
        check_eq("grant_onehot", $onehot(grant), 1);
        check_eq("grant_idle", busy_prev, 0);
        check_eq("grant_done", done, 0);
        if (grant_exp_q.size() == 0) check_eq("grant_unexp", grant, 0);
        else check_eq("grant_id", grant, NREQ'(1) << grant_exp_q.pop_front());
        g = 0;
        for (int k = 0; k < NREQ; k++) if (grant[k]) g = k;
        m = fact_model(n_snap[g]);
        exp_q.push_back({IDW'(g), m[WIDTH], m[WIDTH-1:0], NW'(n_snap[g])});
        gcyc_q.push_back(cyc);
        req = req & ~grant;
        if (resub_valid && grant[resub_id]) begin
          n_arr[resub_id]  = NW'(resub_n);
          n_snap[resub_id] = resub_n;
          req[resub_id]    = 1'b1;
          resub_valid      = 1'b0;
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check_eq("done_unexp", done, 0);
        end else begin
          ent = exp_q.pop_front();
          gc  = gcyc_q.pop_front();
          check_eq("done_id", done_id, ent[EW-1 -: IDW]);
          check_eq("result", result, ent[NW +: WIDTH]);
          check_eq("overflow", overflow, ent[NW+WIDTH]);
          check_eq("latency", cyc - gc, int'(ent[NW-1:0]) + 1);
          last_res = ent[NW +: WIDTH];
          last_ovf = ent[NW+WIDTH];
          last_id  = ent[EW-1 -: IDW];
        end
      end else begin
        check_eq("hold_result", result, last_res);
        check_eq("hold_ovf", overflow, last_ovf);
        check_eq("hold_id", done_id, last_id);
      end
    end
    busy_prev = busy;
  endtask

  task automatic submit(input int k, input int n);
    n_arr[k]  = NW'(n);
    n_snap[k] = n;
    req[k]    = 1'b1;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    tick();
    while ((exp_q.size() != 0 || req != '0 || busy) && c < budget) begin
      tick();
      c++;
    end
    check_eq("drain_timeout", 64'(exp_q.size()) + 64'(req), 0);
  endtask

  task automatic job(input int k, input int n);
    submit(k, n);
    grant_exp_q.push_back(k);
    drain(100);
  endtask

  task automatic clear_model();
    exp_q.delete();
    gcyc_q.delete();
    grant_exp_q.delete();
    last_res    = '0;
    last_ovf    = 1'b0;
    last_id     = '0;
    busy_prev   = 1'b0;
    resub_valid = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_grant", grant, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done_o", done, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_done_id", done_id, 0);
    check_eq("rst_overflow", overflow, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    check_reset_outputs();
    clear_model();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    for (int k = 0; k < NREQ; k++) begin
      n_arr[k]  = '0;
      n_snap[k] = 0;
    end
    resub_id = 0;
    resub_n  = 0;
    clear_model();
    tick();
    tick();
    check_reset_outputs();
    rst = 1'b0;

    // Single job and edge operands, including overflow and flag clear.
    job(0, 5);
    job(2, 0);
    job(2, 1);
    job(2, 12);
    job(2, 13);
    job(2, 3);
    job(3, 31);

    for (int i = 0; i < 6; i++) job(int'($urandom_range(0, NREQ-1)), int'($urandom_range(0, 31)));

    // Contention after reset: order 0,1,2,3 then 0 again.
    pulse_reset();
    submit(0, 3);
    submit(1, 4);
    submit(2, 5);
    submit(3, 6);
    resub_valid = 1'b1;
    resub_id    = 0;
    resub_n     = 2;
    grant_exp_q.push_back(0);
    grant_exp_q.push_back(1);
    grant_exp_q.push_back(2);
    grant_exp_q.push_back(3);
    grant_exp_q.push_back(0);
    drain(300);

    // Operand change one cycle after grant has no effect.
    submit(0, 5);
    grant_exp_q.push_back(0);
    for (int i = 0; i < 10 && exp_q.size() == 0; i++) tick();
    tick();
    n_arr[0] = NW'(9);
    drain(100);

    // Reset in the middle of an n=10 job; the held request is served again.
    submit(1, 10);
    grant_exp_q.push_back(1);
    for (int i = 0; i < 10 && exp_q.size() == 0; i++) tick();
    tick();
    tick();
    tick();
    req[1] = 1'b1;
    pulse_reset();
    grant_exp_q.push_back(1);
    drain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
